// File: rtl/layer_sequencer_pkg.sv
// Shared state encoding and width helpers for the layer sequencer and its bus interface.
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_WRITE,
        S_NEXT,
        S_DONE
    } seq_state_t;

    localparam int MAX_N_DEFAULT = 16;

    // Counts run 0..max_n inclusive, so one extra code point is needed.
    function automatic int cnt_width(input int max_n);
        return $clog2(max_n + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Sequencer <-> config ROM / MAC datapath / activation writer signal bundle.
interface layer_sequencer_if
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int MAX_N      = MAX_N_DEFAULT,
    parameter int WADDR_W    = 10
);
    localparam int CNT_W = cnt_width(MAX_N);
    localparam int LW    = idx_width(NUM_LAYERS);

    logic [LW-1:0]      cfg_layer;
    logic [CNT_W-1:0]   cfg_neurons;
    logic [CNT_W-1:0]   cfg_inputs;
    logic               mac_clear;
    logic               mac_en;
    logic [CNT_W-1:0]   in_addr;
    logic [WADDR_W-1:0] w_addr;
    logic               buf_sel;
    logic               act_valid;
    logic               act_ready;
    logic [CNT_W-1:0]   out_addr;
    logic               busy;
    logic               done;

    modport master (
        output cfg_layer, mac_clear, mac_en, in_addr, w_addr, buf_sel,
               act_valid, out_addr, busy, done,
        input  cfg_neurons, cfg_inputs, act_ready
    );

    modport slave (
        input  cfg_layer, mac_clear, mac_en, in_addr, w_addr, buf_sel,
               act_valid, out_addr, busy, done,
        output cfg_neurons, cfg_inputs, act_ready
    );

endinterface

// File: rtl/layer_sequencer_counter.sv
// Index counter with clear, increment and a terminal-count flag against a supplied last value.
module layer_sequencer_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] cnt,
    output logic         last
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == last_val);

endmodule

// File: rtl/layer_sequencer.sv
// Walks layers/neurons/inputs, driving the MAC datapath and handing each activation to the writer.
//  IDLE wait start | LOAD latch layer cfg | CLEAR zero MAC | ACCUM stream inputs
//  DRAIN MAC pipe  | WRITE act handshake  | NEXT swap bank  | DONE one-cycle pulse
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int  NUM_LAYERS = 3,
    parameter int  MAX_N      = MAX_N_DEFAULT,
    parameter int  MAC_LAT    = 2,
    parameter int  WADDR_W    = 10,
    localparam int CNT_W      = cnt_width(MAX_N),
    localparam int LW         = idx_width(NUM_LAYERS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    layer_sequencer_if.master bus
);
    localparam int               DW      = idx_width(MAC_LAT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_N);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   neurons_q, neurons_d, inputs_q, inputs_d;
    logic [CNT_W-1:0]   cfg_n_clamp, cfg_i_clamp;
    logic [WADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               buf_sel_q, buf_sel_d;
    logic               mac_clear_q, mac_clear_d, mac_en_q, mac_en_d;
    logic               act_valid_q, act_valid_d, busy_q, busy_d, done_q, done_d;
    logic               lay_clr, lay_inc, lay_last;
    logic               neu_clr, neu_inc, neu_last;
    logic               in_clr, in_inc, in_last;
    logic [LW-1:0]      lay_idx;
    logic [CNT_W-1:0]   neu_idx, in_idx;

    layer_sequencer_counter #(.W(LW)) u_lay_cnt (
        .clk(clk), .rst(rst), .clr(lay_clr), .inc(lay_inc),
        .last_val(LW'(NUM_LAYERS - 1)), .cnt(lay_idx), .last(lay_last)
    );

    layer_sequencer_counter #(.W(CNT_W)) u_neu_cnt (
        .clk(clk), .rst(rst), .clr(neu_clr), .inc(neu_inc),
        .last_val(neurons_q - 1'b1), .cnt(neu_idx), .last(neu_last)
    );

    layer_sequencer_counter #(.W(CNT_W)) u_in_cnt (
        .clk(clk), .rst(rst), .clr(in_clr), .inc(in_inc),
        .last_val(inputs_q - 1'b1), .cnt(in_idx), .last(in_last)
    );

    always_comb begin
        cfg_n_clamp = (bus.cfg_neurons > MAX_CNT) ? MAX_CNT : bus.cfg_neurons;
        cfg_i_clamp = (bus.cfg_inputs > MAX_CNT) ? MAX_CNT : bus.cfg_inputs;
        state_d   = state_q;
        neurons_d = neurons_q;
        inputs_d  = inputs_q;
        w_addr_d  = w_addr_q;
        drain_d   = drain_q;
        buf_sel_d = buf_sel_q;
        lay_clr   = 1'b0;
        lay_inc   = 1'b0;
        neu_clr   = 1'b0;
        neu_inc   = 1'b0;
        in_clr    = 1'b0;
        in_inc    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    lay_clr   = 1'b1;
                    w_addr_d  = '0;
                    buf_sel_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                neurons_d = cfg_n_clamp;
                inputs_d  = cfg_i_clamp;
                neu_clr   = 1'b1;
                state_d   = (cfg_n_clamp == '0 || cfg_i_clamp == '0) ? S_NEXT : S_CLEAR;
            end
            S_CLEAR: begin
                in_clr  = 1'b1;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                w_addr_d = w_addr_q + 1'b1;
                in_inc   = !in_last;
                if (in_last) begin
                    drain_d = '0;
                    state_d = (MAC_LAT == 0) ? S_WRITE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DW'(MAC_LAT - 1)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.act_ready) begin
                    neu_inc = !neu_last;
                    state_d = neu_last ? S_NEXT : S_CLEAR;
                end
            end
            S_NEXT: begin
                buf_sel_d = ~buf_sel_q;
                lay_inc   = !lay_last;
                state_d   = lay_last ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel returns everything to the post-reset picture, counters included.
        if (abort) begin
            state_d   = S_IDLE;
            neurons_d = '0;
            inputs_d  = '0;
            w_addr_d  = '0;
            drain_d   = '0;
            buf_sel_d = 1'b0;
            lay_clr   = 1'b1;
            neu_clr   = 1'b1;
            in_clr    = 1'b1;
            lay_inc   = 1'b0;
            neu_inc   = 1'b0;
            in_inc    = 1'b0;
        end

        mac_clear_d = (state_d == S_CLEAR);
        mac_en_d    = (state_d == S_ACCUM);
        act_valid_d = (state_d == S_WRITE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            neurons_q   <= '0;
            inputs_q    <= '0;
            w_addr_q    <= '0;
            drain_q     <= '0;
            buf_sel_q   <= 1'b0;
            mac_clear_q <= 1'b0;
            mac_en_q    <= 1'b0;
            act_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            neurons_q   <= neurons_d;
            inputs_q    <= inputs_d;
            w_addr_q    <= w_addr_d;
            drain_q     <= drain_d;
            buf_sel_q   <= buf_sel_d;
            mac_clear_q <= mac_clear_d;
            mac_en_q    <= mac_en_d;
            act_valid_q <= act_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.cfg_layer = lay_idx;
    assign bus.in_addr   = in_idx;
    assign bus.out_addr  = neu_idx;
    assign bus.w_addr    = w_addr_q;
    assign bus.buf_sel   = buf_sel_q;
    assign bus.mac_clear = mac_clear_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.act_valid = act_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench: single-layer timing/stall/abort/reset cases on one instance, multi-layer skip and clamp on another.
module tb_layer_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic start_a, abort_a, ready_a;
    logic start_b, abort_b, ready_b;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    layer_sequencer_if #(.NUM_LAYERS(1), .MAX_N(16), .WADDR_W(10)) bus_a ();
    layer_sequencer_if #(.NUM_LAYERS(3), .MAX_N(16), .WADDR_W(10)) bus_b ();

    layer_sequencer #(.NUM_LAYERS(1), .MAX_N(16), .MAC_LAT(2), .WADDR_W(10)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .bus(bus_a.master)
    );

    layer_sequencer #(.NUM_LAYERS(3), .MAX_N(16), .MAC_LAT(2), .WADDR_W(10)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .bus(bus_b.master)
    );

    // Layer 1 is empty; layer 2 asks for 20 inputs, which must clamp to 16.
    function automatic logic [4:0] rom_n(input logic [1:0] l);
        case (l)
            2'd0:    return 5'd1;
            2'd1:    return 5'd0;
            default: return 5'd1;
        endcase
    endfunction

    function automatic logic [4:0] rom_i(input logic [1:0] l);
        case (l)
            2'd0:    return 5'd2;
            2'd1:    return 5'd4;
            default: return 5'd20;
        endcase
    endfunction

    assign bus_a.cfg_neurons = 5'd2;
    assign bus_a.cfg_inputs  = 5'd3;
    assign bus_a.act_ready   = ready_a;
    assign bus_b.cfg_neurons = rom_n(bus_b.cfg_layer);
    assign bus_b.cfg_inputs  = rom_i(bus_b.cfg_layer);
    assign bus_b.act_ready   = ready_b;

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, ".busy"},      int'(bus_a.busy),      0);
        chk({tag, ".done"},      int'(bus_a.done),      0);
        chk({tag, ".mac_clear"}, int'(bus_a.mac_clear), 0);
        chk({tag, ".mac_en"},    int'(bus_a.mac_en),    0);
        chk({tag, ".act_valid"}, int'(bus_a.act_valid), 0);
        chk({tag, ".w_addr"},    int'(bus_a.w_addr),    0);
        chk({tag, ".in_addr"},   int'(bus_a.in_addr),   0);
        chk({tag, ".out_addr"},  int'(bus_a.out_addr),  0);
        chk({tag, ".buf_sel"},   int'(bus_a.buf_sel),   0);
        chk({tag, ".cfg_layer"}, int'(bus_a.cfg_layer), 0);
    endtask

    // One run of instance A (2 neurons x 3 inputs, MAC_LAT 2); start seen at c0.
    task automatic run_a(input string tag, input int stall_len, input int restart_at);
        int mac_n, in_exp, done_n, done_c, wr_n, stall, excl, busy_n;
        mac_n = 0; in_exp = 0; done_n = 0; done_c = -1; wr_n = 0;
        stall = 0; excl = 0; busy_n = 0;
        ready_a = (stall_len == 0);
        @(negedge clk);
        start_a = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_a = (k == restart_at);
            if (bus_a.busy) busy_n++;
            if (int'(bus_a.mac_clear) + int'(bus_a.mac_en) + int'(bus_a.act_valid) > 1) excl++;
            if (bus_a.mac_clear) in_exp = 0;
            if (bus_a.mac_en) begin
                chk({tag, ".w_addr"}, int'(bus_a.w_addr), mac_n);
                chk({tag, ".in_addr"}, int'(bus_a.in_addr), in_exp);
                in_exp++;
                mac_n++;
            end
            if (bus_a.act_valid) begin
                if (!ready_a) begin
                    if (stall == stall_len) begin
                        ready_a = 1'b1;
                    end else begin
                        stall++;
                        chk({tag, ".stall_out_addr"}, int'(bus_a.out_addr), wr_n);
                    end
                end
                if (ready_a) begin
                    chk({tag, ".wr_cycle"}, k, (wr_n == 0) ? 8 + stall_len : 15 + stall_len);
                    chk({tag, ".out_addr"}, int'(bus_a.out_addr), wr_n);
                    wr_n++;
                end
            end
            if (bus_a.done) begin
                done_n++;
                done_c = k;
            end
        end
        ready_a = 1'b1;
        chk({tag, ".mac_cycles"}, mac_n, 6);
        chk({tag, ".writes"}, wr_n, 2);
        chk({tag, ".stall_cycles"}, stall, stall_len);
        chk({tag, ".done_count"}, done_n, 1);
        chk({tag, ".done_cycle"}, done_c, 17 + stall_len);
        chk({tag, ".busy_cycles"}, busy_n, 17 + stall_len);
        chk({tag, ".exclusive"}, excl, 0);
    endtask

    initial begin
        int done_n, mac_n, l1_mac, tog, wr_n, in_exp;
        logic prev_sel;
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_a("reset");
        chk("reset.busy_b", int'(bus_b.busy), 0);
        rst = 1'b0;
        @(negedge clk);

        run_a("basic", 0, 0);
        run_a("stall", 5, 0);
        run_a("restart", 0, 3);

        // start and abort together while idle: abort wins
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        chk("start_abort.busy", int'(bus_a.busy), 0);
        repeat (2) @(negedge clk);
        chk("start_abort.busy_later", int'(bus_a.busy), 0);

        // abort in the first ACCUM cycle (c3)
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort.in_accum", int'(bus_a.mac_en), 1);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk_idle_a("abort");
        done_n = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus_a.done || bus_a.busy) done_n++;
        end
        chk("abort.no_done", done_n, 0);

        // reset in the first DRAIN cycle (c6)
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst.in_drain_busy", int'(bus_a.busy), 1);
        chk("rst.in_drain_mac_en", int'(bus_a.mac_en), 0);
        chk("rst.in_drain_valid", int'(bus_a.act_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_a("rst");
        run_a("after_rst", 0, 0);

        // three layers, empty middle layer, clamped input count in the last
        mac_n = 0; l1_mac = 0; tog = 0; wr_n = 0; done_n = 0; in_exp = 0;
        prev_sel = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (bus_b.mac_clear) in_exp = 0;
            if (bus_b.mac_en) begin
                chk("multi.w_addr", int'(bus_b.w_addr), mac_n);
                chk("multi.in_addr", int'(bus_b.in_addr), in_exp);
                if (bus_b.cfg_layer == 2'd1) l1_mac++;
                in_exp++;
                mac_n++;
            end
            if (bus_b.buf_sel != prev_sel) begin
                tog++;
                prev_sel = bus_b.buf_sel;
            end
            if (bus_b.act_valid) wr_n++;
            if (bus_b.done) done_n++;
        end
        chk("multi.mac_cycles", mac_n, 18);
        chk("multi.layer1_mac", l1_mac, 0);
        chk("multi.buf_toggles", tog, 3);
        chk("multi.final_buf_sel", int'(bus_b.buf_sel), 1);
        chk("multi.writes", wr_n, 2);
        chk("multi.done_count", done_n, 1);
        chk("multi.idle_after", int'(bus_b.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
